// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter between the trace stream and the status stream.
// Ownership changes only at frame boundaries; ties are round-robin and a stalled owner is timed out.
module uart_tx_arb #(
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            t_valid,
  input  logic [7:0]      t_data,
  input  logic            t_last,
  output logic            t_ack,
  input  logic            s_valid,
  input  logic [7:0]      s_data,
  input  logic            s_last,
  output logic            s_ack,
  output logic            transmit,
  output logic [7:0]      tx_byte,
  input  logic            tx_free,
  output logic [1:0]      grant,
  output logic [CNTW-1:0] abort_cnt
);

  // state   | meaning
  // IDLE    | no owner; arbitrate when the uart is free and a source is valid
  // XFER    | owner holds the uart; send its next byte or count a stall
  // WAIT_LO | byte handed off; wait for the uart to show busy (bounded)
  // WAIT_HI | wait for the uart to go idle; release on the frame's last byte
  typedef enum logic [1:0] {IDLE, XFER, WAIT_LO, WAIT_HI} state_e;

  localparam int         TW      = $clog2(TIMEOUT + 1);
  localparam logic [1:0] G_NONE  = 2'b00;
  localparam logic [1:0] G_TRACE = 2'b01;
  localparam logic [1:0] G_STAT  = 2'b10;

  state_e          state_q;
  logic [1:0]      grant_q;
  logic            last_win_q;   // 1: status won the previous frame
  logic            last_q;
  logic [TW-1:0]   tmo_q;
  logic [2:0]      lo_cnt_q;
  logic            transmit_q;
  logic            t_ack_q;
  logic            s_ack_q;
  logic [7:0]      tx_byte_q;
  logic [CNTW-1:0] abort_q;

  logic       o_valid;
  logic       o_last;
  logic [7:0] o_data;
  logic       pick_s_d;

  assign o_valid  = grant_q[1] ? s_valid : t_valid;
  assign o_last   = grant_q[1] ? s_last  : t_last;
  assign o_data   = grant_q[1] ? s_data  : t_data;
  assign pick_s_d = s_valid && (!t_valid || !last_win_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= G_NONE;
      last_win_q <= 1'b1;
      last_q     <= 1'b0;
      tmo_q      <= '0;
      lo_cnt_q   <= '0;
      transmit_q <= 1'b0;
      t_ack_q    <= 1'b0;
      s_ack_q    <= 1'b0;
      tx_byte_q  <= '0;
      abort_q    <= '0;
    end else begin
      transmit_q <= 1'b0;
      t_ack_q    <= 1'b0;
      s_ack_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tx_free && (t_valid || s_valid)) begin
            grant_q <= pick_s_d ? G_STAT : G_TRACE;
            tmo_q   <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (o_valid && tx_free) begin
            transmit_q <= 1'b1;
            tx_byte_q  <= o_data;
            t_ack_q    <= grant_q[0];
            s_ack_q    <= grant_q[1];
            last_q     <= o_last;
            tmo_q      <= '0;
            lo_cnt_q   <= '0;
            state_q    <= WAIT_LO;
          end else if (!o_valid) begin
            // a valid owner blocked only by a busy uart is not stalling
            if (tmo_q == TW'(TIMEOUT - 1)) begin
              grant_q    <= G_NONE;
              last_win_q <= grant_q[1];
              tmo_q      <= '0;
              if (abort_q != '1) abort_q <= abort_q + CNTW'(1);
              state_q    <= IDLE;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
        end
        WAIT_LO: begin
          if (!tx_free || lo_cnt_q == 3'd7) state_q <= WAIT_HI;
          else                               lo_cnt_q <= lo_cnt_q + 3'd1;
        end
        WAIT_HI: begin
          if (tx_free) begin
            if (last_q) begin
              last_win_q <= grant_q[1];
              grant_q    <= G_NONE;
              state_q    <= IDLE;
            end else begin
              state_q <= XFER;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign transmit  = transmit_q;
  assign tx_byte   = tx_byte_q;
  assign t_ack     = t_ack_q;
  assign s_ack     = s_ack_q;
  assign grant     = grant_q;
  assign abort_cnt = abort_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queue-fed source models, a busy-time uart model and a frame-order reference.
module tb_uart_tx_arb;
  localparam int TIMEOUT = 16;
  localparam int CNTW    = 2;
  localparam int AB_MAX  = (1 << CNTW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            t_valid, t_last, t_ack;
  logic [7:0]      t_data;
  logic            s_valid, s_last, s_ack;
  logic [7:0]      s_data;
  logic            transmit, tx_free;
  logic [7:0]      tx_byte;
  logic [1:0]      grant;
  logic [CNTW-1:0] abort_cnt;

  uart_tx_arb #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .t_valid(t_valid), .t_data(t_data), .t_last(t_last), .t_ack(t_ack),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ack(s_ack),
    .transmit(transmit), .tx_byte(tx_byte), .tx_free(tx_free),
    .grant(grant), .abort_cnt(abort_cnt)
  );

  typedef struct packed {
    logic       tv;
    logic       sv;
    logic [1:0] g0;
    logic [1:0] g1;
  } arb_vec_t;

  logic [8:0] tq[$];          // {last, data} pending at each source
  logic [8:0] sq[$];
  logic [9:0] txlog[$];       // {grant, byte} of every transmit
  int         txcyc[$];
  logic [9:0] expq[$];
  arb_vec_t   vec[7];

  int cycle = 0, n_checks = 0, n_fail = 0;
  int t_acks = 0, s_acks = 0;
  int busy_lo = 2, busy_hi = 2, gap_max = 0;
  int busy_left = 0, t_gap = 0, s_gap = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  function automatic void monitor();
    if (transmit || t_ack || s_ack) begin
      check("t_ack_with_transmit", t_ack, transmit && grant == 2'b01);
      check("s_ack_with_transmit", s_ack, transmit && grant == 2'b10);
    end
    if (transmit) begin
      check("uart_free_at_send", tx_free, 1);
      txlog.push_back({grant, tx_byte});
      txcyc.push_back(cycle);
    end
    if (t_ack) t_acks++;
    if (s_ack) s_acks++;
  endfunction

  function automatic void check_log(string name, logic [9:0] exp[$]);
    check({name, "_len"}, txlog.size(), exp.size());
    foreach (exp[i])
      if (i < txlog.size()) check($sformatf("%s_tx%0d", name, i), txlog[i], exp[i]);
  endfunction

  function automatic logic [7:0] vec_byte(logic [1:0] g, int i);
    return (g == 2'b01) ? 8'(64 + i) : 8'(96 + i);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    monitor();
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      cyc();
      if (tq.size() == 0 && sq.size() == 0 && grant == 2'b00 && tx_free && !t_valid && !s_valid)
        done = 1;
    end
    check({name, "_reached_idle"}, done, 1);
  endtask

  task automatic wait_tx(input string name);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cyc();
      if (transmit) seen = 1;
    end
    check({name, "_transmit_seen"}, seen, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
  endtask

  // Source and uart models: sample DUT outputs and drive inputs on the falling edge.
  initial begin
    t_valid = 0; t_data = 0; t_last = 0;
    s_valid = 0; s_data = 0; s_last = 0;
    tx_free = 1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        tq.delete(); sq.delete();
        t_valid = 0; s_valid = 0; tx_free = 1;
        busy_left = 0; t_gap = 0; s_gap = 0;
      end else begin
        if (transmit) begin
          busy_left = $urandom_range(busy_hi, busy_lo);
          tx_free = (busy_left == 0);
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) tx_free = 1;
        end
        if (t_ack) begin
          if (tq.size() > 0) void'(tq.pop_front());
          t_gap = $urandom_range(gap_max, 0);
        end
        if (s_ack) begin
          if (sq.size() > 0) void'(sq.pop_front());
          s_gap = $urandom_range(gap_max, 0);
        end
        if (t_gap > 0) begin
          t_gap--; t_valid = 0;
        end else if (tq.size() > 0) begin
          t_valid = 1; {t_last, t_data} = tq[0];
        end else t_valid = 0;
        if (s_gap > 0) begin
          s_gap--; s_valid = 0;
        end else if (sq.size() > 0) begin
          s_valid = 1; {s_last, s_data} = sq[0];
        end else s_valid = 0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         req_cyc, cnt, len;
    bit         rel;
    logic [7:0] b;
    logic [1:0] g;

    vec[0] = '{1'b1, 1'b1, 2'b10, 2'b01};
    vec[1] = '{1'b1, 1'b1, 2'b10, 2'b01};
    vec[2] = '{1'b0, 1'b1, 2'b10, 2'b00};
    vec[3] = '{1'b1, 1'b1, 2'b01, 2'b10};
    vec[4] = '{1'b1, 1'b0, 2'b01, 2'b00};
    vec[5] = '{1'b0, 1'b1, 2'b10, 2'b00};
    vec[6] = '{1'b1, 1'b1, 2'b01, 2'b10};

    rst = 1'b0;
    repeat (3) cyc();
    check("rst_transmit", transmit, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_t_ack", t_ack, 0);
    check("rst_s_ack", s_ack, 0);
    check("rst_grant", grant, 0);
    check("rst_abort_cnt", abort_cnt, 0);
    rst = 1'b1;
    cyc();

    // Trace-only three-byte frame with a 10-cycle busy uart
    busy_lo = 10; busy_hi = 10;
    txlog.delete(); txcyc.delete(); t_acks = 0;
    tq.push_back({1'b0, 8'hA1}); tq.push_back({1'b0, 8'hA2}); tq.push_back({1'b1, 8'hA3});
    req_cyc = -1;
    for (int i = 0; i < 20 && txcyc.size() == 0; i++) begin
      cyc();
      if (t_valid && req_cyc < 0) begin
        req_cyc = cycle;
        check("t1_grant_on_request", grant, 2'b01);
      end
    end
    check("t1_request_to_transmit", (txcyc.size() > 0) ? txcyc[0] - req_cyc : -1, 1);
    wait_idle("t1", 500);
    expq = '{{2'b01, 8'hA1}, {2'b01, 8'hA2}, {2'b01, 8'hA3}};
    check_log("t1", expq);
    check("t1_t_acks", t_acks, 3);
    check("t1_abort_cnt", abort_cnt, 0);

    // One-byte frames on tie/solo patterns; last winner is trace here
    busy_lo = 2; busy_hi = 2;
    for (int i = 0; i < 7; i++) begin
      txlog.delete();
      expq.delete();
      if (vec[i].tv) tq.push_back({1'b1, vec_byte(2'b01, i)});
      if (vec[i].sv) sq.push_back({1'b1, vec_byte(2'b10, i)});
      if (vec[i].g0 != 2'b00) expq.push_back({vec[i].g0, vec_byte(vec[i].g0, i)});
      if (vec[i].g1 != 2'b00) expq.push_back({vec[i].g1, vec_byte(vec[i].g1, i)});
      wait_idle($sformatf("vec%0d", i), 300);
      check_log($sformatf("vec%0d", i), expq);
    end

    // Simultaneous two-byte frames straight after reset: trace first, no interleave
    do_reset();
    txlog.delete();
    tq.push_back({1'b0, 8'hD1}); tq.push_back({1'b1, 8'hD2});
    sq.push_back({1'b0, 8'hE1}); sq.push_back({1'b1, 8'hE2});
    wait_idle("t2", 500);
    expq = '{{2'b01, 8'hD1}, {2'b01, 8'hD2}, {2'b10, 8'hE1}, {2'b10, 8'hE2}};
    check_log("t2", expq);

    // Status arrives mid trace frame
    txlog.delete();
    tq.push_back({1'b0, 8'h31}); tq.push_back({1'b0, 8'h32});
    tq.push_back({1'b0, 8'h33}); tq.push_back({1'b1, 8'h34});
    wait_tx("t3");
    sq.push_back({1'b0, 8'h51}); sq.push_back({1'b1, 8'h52});
    wait_idle("t3", 800);
    expq = '{{2'b01, 8'h31}, {2'b01, 8'h32}, {2'b01, 8'h33}, {2'b01, 8'h34},
             {2'b10, 8'h51}, {2'b10, 8'h52}};
    check_log("t3", expq);

    // Trace stalls after its first byte; repeated until abort_cnt saturates
    busy_lo = 3; busy_hi = 3;
    for (int i = 0; i < AB_MAX + 1; i++) begin
      txlog.delete();
      tq.push_back({1'b0, 8'(8'hB0 + i)});
      wait_tx($sformatf("t4_%0d", i));
      sq.push_back({1'b1, 8'(8'hC0 + i)});
      cnt = 0; rel = 0;
      for (int k = 0; k < 200 && !rel; k++) begin
        cyc();
        if (grant != 2'b01) rel = 1;
        else if (tx_free && !t_valid) cnt++;
      end
      check($sformatf("t4_%0d_released", i), rel, 1);
      check($sformatf("t4_%0d_grant_after", i), grant, 2'b00);
      check($sformatf("t4_%0d_stall_cycles", i), cnt, TIMEOUT);
      check($sformatf("t4_%0d_abort_cnt", i), abort_cnt, (i + 1 > AB_MAX) ? AB_MAX : i + 1);
      wait_idle($sformatf("t4_%0d", i), 300);
      expq = '{{2'b01, 8'(8'hB0 + i)}, {2'b10, 8'(8'hC0 + i)}};
      check_log($sformatf("t4_%0d", i), expq);
    end

    // Uart that never shows busy: each byte waits out the 8-cycle guard
    busy_lo = 0; busy_hi = 0;
    txlog.delete(); txcyc.delete(); t_acks = 0;
    tq.push_back({1'b0, 8'h91}); tq.push_back({1'b0, 8'h92}); tq.push_back({1'b1, 8'h93});
    wait_idle("t5", 300);
    expq = '{{2'b01, 8'h91}, {2'b01, 8'h92}, {2'b01, 8'h93}};
    check_log("t5", expq);
    check("t5_t_acks", t_acks, 3);
    if (txcyc.size() == 3) begin
      check("t5_spacing_1", txcyc[1] - txcyc[0], 10);
      check("t5_spacing_2", txcyc[2] - txcyc[1], 10);
    end

    // Reset while waiting for the uart mid-frame
    busy_lo = 10; busy_hi = 10;
    tq.push_back({1'b0, 8'hF1}); tq.push_back({1'b0, 8'hF2}); tq.push_back({1'b1, 8'hF3});
    wait_tx("t6");
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    check("t6_rst_transmit", transmit, 0);
    check("t6_rst_tx_byte", tx_byte, 0);
    check("t6_rst_t_ack", t_ack, 0);
    check("t6_rst_s_ack", s_ack, 0);
    check("t6_rst_grant", grant, 0);
    check("t6_rst_abort_cnt", abort_cnt, 0);
    cyc();
    rst = 1'b1;
    cyc();
    txlog.delete(); t_acks = 0; s_acks = 0;
    tq.push_back({1'b1, 8'h71});
    sq.push_back({1'b1, 8'h72});
    wait_idle("t6", 300);
    expq = '{{2'b01, 8'h71}, {2'b10, 8'h72}};
    check_log("t6", expq);
    check("t6_t_acks", t_acks, 1);
    check("t6_s_acks", s_acks, 1);

    // Random frames on both sources: with both always pending, frames alternate T,S,T,S
    busy_lo = 0; busy_hi = 12; gap_max = 2;
    txlog.delete(); expq.delete();
    for (int f = 0; f < 6; f++) begin
      for (int src = 0; src < 2; src++) begin
        len = $urandom_range(4, 1);
        g = (src == 0) ? 2'b01 : 2'b10;
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          if (src == 0) tq.push_back({k == len - 1, b});
          else          sq.push_back({k == len - 1, b});
          expq.push_back({g, b});
        end
      end
    end
    wait_idle("rand", 20000);
    check_log("rand", expq);
    check("rand_abort_cnt", abort_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
